// File: rtl/rf_write_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : rf_write_arbiter_pkg
//  Purpose  : Shared widths, FSM state encoding and constants for the
//             register-file write-port arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package rf_write_arbiter_pkg;

    localparam int AW_DEFAULT = 5;
    localparam int DW_DEFAULT = 32;

    // x0 is hard-wired to zero; writes addressed to it are accepted and dropped
    localparam int REG_ZERO   = 0;

    // Highest register zeroed by the clear sequence (x1..x31)
    localparam int CLEAR_LAST = 31;

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

endpackage : rf_write_arbiter_pkg
`default_nettype wire

// File: rtl/rf_write_arbiter_rr_arbiter2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arbiter2
//  Purpose  : Two-way round-robin grant. A lone requester always wins; on a
//             tie the requester that did not win last time is granted.
//  Revision : 1.0  initial release
// ============================================================================
module rr_arbiter2
    import rf_write_arbiter_pkg::*;
(
    input  logic valid0,
    input  logic valid1,
    input  logic last_grant,
    output logic gnt0,
    output logic gnt1
);

    // At most one grant, and never a grant without its valid
    always_comb begin
        gnt0 = valid0 & (~valid1 | last_grant);
        gnt1 = valid1 & (~valid0 | ~last_grant);
    end

endmodule : rr_arbiter2
`default_nettype wire

// File: rtl/rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : rf_write_arbiter
//  Purpose  : Shares the register file write port between two valid/ready
//             write-back requesters (round-robin on ties) and runs a clear
//             sequence that zeroes x1..x31 after reset and on request.
//  Revision : 1.0  initial release
// ============================================================================
module rf_write_arbiter
    import rf_write_arbiter_pkg::*;
#(
    parameter int AW             = AW_DEFAULT,
    parameter int DW             = DW_DEFAULT,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_data,
    output logic          req0_ready,
    input  logic          req1_valid,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_data,
    output logic          req1_ready,
    input  logic          clear_start,
    output logic          clear_busy,
    output logic          clear_done,
    output logic          rf_we,
    output logic [AW-1:0] rf_addr,
    output logic [DW-1:0] rf_data
);

    localparam logic [AW-1:0] c_LAST_REG  = AW'(CLEAR_LAST);
    localparam logic [AW-1:0] c_FIRST_REG = AW'(1);
    localparam logic [AW-1:0] c_ZERO_REG  = AW'(REG_ZERO);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [AW-1:0] r_cnt;
    logic [AW-1:0] w_cnt_nxt;
    logic          r_last_grant;
    logic          r_rf_we;
    logic [AW-1:0] r_rf_addr;
    logic [DW-1:0] r_rf_data;
    logic          r_clear_done;
    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_arb_en;

    rr_arbiter2 u_rr (
        .valid0     (req0_valid),
        .valid1     (req1_valid),
        .last_grant (r_last_grant),
        .gnt0       (w_gnt0),
        .gnt1       (w_gnt1)
    );

    // Grants only in ARB, and a same-cycle clear request suppresses them
    always_comb begin
        w_arb_en   = (r_state == ST_ARB) & ~clear_start;
        req0_ready = w_arb_en & w_gnt0;
        req1_ready = w_arb_en & w_gnt1;
        clear_busy = (r_state == ST_CLEAR);
    end

    // FSM state and clear-counter register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
            r_cnt   <= c_FIRST_REG;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next state: enter CLEAR on request, leave after the x31 write
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_ARB: begin
                if (clear_start) begin
                    w_state_nxt = ST_CLEAR;
                    w_cnt_nxt   = c_FIRST_REG;
                end
            end
            ST_CLEAR: begin
                if (r_cnt == c_LAST_REG) begin
                    w_state_nxt = ST_ARB;
                    w_cnt_nxt   = c_FIRST_REG;
                end else begin
                    w_cnt_nxt   = r_cnt + AW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_ARB;
                w_cnt_nxt   = c_FIRST_REG;
            end
        endcase
    end

    // Registered write port: clear writes, granted writes (x0 dropped), or idle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rf_we      <= 1'b0;
            r_rf_addr    <= '0;
            r_rf_data    <= '0;
            r_clear_done <= 1'b0;
            r_last_grant <= 1'b1;
        end else begin
            r_rf_we      <= 1'b0;
            r_clear_done <= 1'b0;
            if (r_state == ST_CLEAR) begin
                r_rf_we      <= 1'b1;
                r_rf_addr    <= r_cnt;
                r_rf_data    <= '0;
                r_clear_done <= (r_cnt == c_LAST_REG);
            end else if (req0_valid && req0_ready) begin
                r_rf_we      <= (req0_addr != c_ZERO_REG);
                r_rf_addr    <= req0_addr;
                r_rf_data    <= req0_data;
                r_last_grant <= 1'b0;
            end else if (req1_valid && req1_ready) begin
                r_rf_we      <= (req1_addr != c_ZERO_REG);
                r_rf_addr    <= req1_addr;
                r_rf_data    <= req1_data;
                r_last_grant <= 1'b1;
            end
        end
    end

    assign rf_we      = r_rf_we;
    assign rf_addr    = r_rf_addr;
    assign rf_data    = r_rf_data;
    assign clear_done = r_clear_done;

endmodule : rf_write_arbiter
`default_nettype wire

// File: tb/tb_rf_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_write_arbiter
//  Purpose  : Self-checking bench for rf_write_arbiter with a behavioural
//             reference model of the grant rules and the clear sequence.
//  Revision : 1.0  initial release
// ============================================================================
module tb_rf_write_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req1_valid, clear_start;
    logic [4:0]  req0_addr, req1_addr;
    logic [31:0] req0_data, req1_data;
    logic        req0_ready, req1_ready, clear_busy, clear_done, rf_we;
    logic [4:0]  rf_addr;
    logic [31:0] rf_data;

    int checks = 0;
    int errors = 0;

    // Reference model state
    bit          m_clearing;
    int          m_idx;
    int          m_last;
    int          m_g;
    bit          e_rdy0, e_rdy1, e_busy, e_we, e_done;
    logic [4:0]  e_addr;
    logic [31:0] e_data;

    rf_write_arbiter #(.AW(5), .DW(32), .CLEAR_ON_RESET(1'b1)) dut (
        .clk         (clk),
        .rst         (rst),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .clear_done  (clear_done),
        .rf_we       (rf_we),
        .rf_addr     (rf_addr),
        .rf_data     (rf_data)
    );

    always #5 clk = ~clk;

    task automatic set_in(input logic v0, input logic [4:0] a0, input logic [31:0] d0,
                          input logic v1, input logic [4:0] a1, input logic [31:0] d1,
                          input logic cs);
        req0_valid = v0; req0_addr = a0; req0_data = d0;
        req1_valid = v1; req1_addr = a1; req1_data = d1;
        clear_start = cs;
    endtask

    task automatic set_random(input logic cs);
        set_in(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
               1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom, cs);
    endtask

    // Half-cycle before the edge: expected readys from the grant rules
    task automatic half_a();
        @(negedge clk);
        e_busy = m_clearing;
        m_g    = -1;
        if (!m_clearing && !clear_start) begin
            if (req0_valid && req1_valid) m_g = 1 - m_last;
            else if (req0_valid)          m_g = 0;
            else if (req1_valid)          m_g = 1;
        end
        e_rdy0 = (m_g == 0);
        e_rdy1 = (m_g == 1);
    endtask

    // Edge: expected write-port contents after the rising edge
    task automatic half_b();
        logic [4:0] a;
        @(posedge clk);
        e_done = 1'b0;
        e_we   = 1'b0;
        if (rst) begin
            e_addr = '0; e_data = '0; m_last = 1; m_clearing = 1'b1; m_idx = 1;
        end else if (m_clearing) begin
            e_we = 1'b1; e_addr = 5'(m_idx); e_data = '0; e_done = (m_idx == 31);
            if (m_idx == 31) m_clearing = 1'b0;
            else             m_idx++;
        end else if (clear_start) begin
            m_clearing = 1'b1; m_idx = 1;
        end else if (m_g >= 0) begin
            a      = (m_g == 1) ? req1_addr : req0_addr;
            e_data = (m_g == 1) ? req1_data : req0_data;
            e_addr = a;
            e_we   = (a != 5'd0);
            m_last = m_g;
        end
        #1;
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        repeat (2) begin half_a(); half_b(); end
        checks++;
        if (rf_we !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 32'd0 ||
            clear_done !== 1'b0 || clear_busy !== 1'b1) begin
            errors++;
            $display("FAIL reset: we=%b addr=%0d data=%h done=%b busy=%b, want 0 0 0 0 1",
                     rf_we, rf_addr, rf_data, clear_done, clear_busy);
        end
        rst = 1'b0;
    endtask

    task automatic test_clear_after_reset();
        int writes = 0, dones = 0;
        for (int i = 1; i <= 31; i++) begin
            set_random(1'b0);
            half_a();
            checks++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || clear_busy !== 1'b1) begin
                errors++;
                $display("FAIL clear_ctl[%0d]: rdy=%b%b busy=%b, want 00 1",
                         i, req0_ready, req1_ready, clear_busy);
            end
            half_b();
            checks++;
            if (rf_we !== 1'b1 || rf_addr !== 5'(i) || rf_data !== 32'd0 ||
                clear_done !== (i == 31)) begin
                errors++;
                $display("FAIL clear_wr[%0d]: we=%b addr=%0d data=%h done=%b, want 1 %0d 0 %b",
                         i, rf_we, rf_addr, rf_data, clear_done, i, (i == 31));
            end
            writes += int'(rf_we);
            dones  += int'(clear_done);
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        half_a();
        checks++;
        if (writes != 31 || dones != 1 || clear_busy !== 1'b0) begin
            errors++;
            $display("FAIL clear_end: writes=%0d dones=%0d busy=%b, want 31 1 0",
                     writes, dones, clear_busy);
        end
        half_b();
    endtask

    task automatic test_alternate();
        logic [4:0] want_addr [4] = '{5'd3, 5'd7, 5'd3, 5'd7};
        for (int i = 0; i < 4; i++) begin
            set_in(1, 5'd3, $urandom, 1, 5'd7, $urandom, 0);
            half_a();
            checks++;
            if (req0_ready !== (i % 2 == 0) || req1_ready !== (i % 2 == 1)) begin
                errors++;
                $display("FAIL alt_grant[%0d]: rdy=%b%b, want %b%b",
                         i, req0_ready, req1_ready, (i % 2 == 0), (i % 2 == 1));
            end
            half_b();
            checks++;
            if (rf_we !== 1'b1 || rf_addr !== want_addr[i] || rf_data !== e_data) begin
                errors++;
                $display("FAIL alt_wr[%0d]: we=%b addr=%0d data=%h, want 1 %0d %h",
                         i, rf_we, rf_addr, rf_data, want_addr[i], e_data);
            end
        end
    endtask

    task automatic test_single();
        set_in(1, 5'd5, 32'hDEADBEEF, 0, 0, 0, 0);
        half_a();
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL single_rdy: rdy=%b%b, want 10", req0_ready, req1_ready);
        end
        half_b();
        checks++;
        if (rf_we !== 1'b1 || rf_addr !== 5'd5 || rf_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL single_wr: we=%b addr=%0d data=%h, want 1 5 deadbeef",
                     rf_we, rf_addr, rf_data);
        end
        set_in(0, 0, 0, 0, 0, 0, 0);
        half_a(); half_b();
        checks++;
        if (rf_we !== 1'b0 || rf_addr !== 5'd5 || rf_data !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL idle_hold: we=%b addr=%0d data=%h, want 0 5 deadbeef",
                     rf_we, rf_addr, rf_data);
        end
    endtask

    task automatic test_x0_write();
        set_in(0, 0, 0, 1, 5'd0, 32'h1234, 0);
        half_a();
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL x0_rdy: rdy=%b%b, want 01", req0_ready, req1_ready);
        end
        half_b();
        checks++;
        if (rf_we !== 1'b0 || rf_addr !== 5'd0 || rf_data !== 32'h1234) begin
            errors++;
            $display("FAIL x0_wr: we=%b addr=%0d data=%h, want 0 0 1234", rf_we, rf_addr, rf_data);
        end
        // last_grant is now 1, so a tie must go to requester 0
        set_in(1, 5'd9, $urandom, 1, 5'd11, $urandom, 0);
        half_a();
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL x0_last: rdy=%b%b, want 10", req0_ready, req1_ready);
        end
        half_b();
    endtask

    task automatic test_clear_start();
        int writes = 0, dones = 0, n = 0;
        set_in(1, 5'd4, $urandom, 0, 0, 0, 1);
        half_a();
        checks++;
        if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || clear_busy !== 1'b0) begin
            errors++;
            $display("FAIL cs_prio: rdy=%b%b busy=%b, want 00 0", req0_ready, req1_ready, clear_busy);
        end
        half_b();
        checks++;
        if (rf_we !== 1'b0 || clear_busy !== 1'b1) begin
            errors++;
            $display("FAIL cs_enter: we=%b busy=%b, want 0 1", rf_we, clear_busy);
        end
        while (m_clearing && n < 40) begin
            set_random(n == 10);
            half_a(); half_b();
            writes += int'(rf_we);
            dones  += int'(clear_done);
            n++;
        end
        checks++;
        if (writes != 31 || dones != 1 || n != 31) begin
            errors++;
            $display("FAIL cs_seq: writes=%0d dones=%0d cycles=%0d, want 31 1 31", writes, dones, n);
        end
    endtask

    task automatic test_reset_mid_clear();
        int n = 0, writes = 0;
        logic [4:0] first;
        set_in(0, 0, 0, 0, 0, 0, 1);
        half_a(); half_b();
        set_in(0, 0, 0, 0, 0, 0, 0);
        while (!(rf_we === 1'b1 && rf_addr === 5'd10) && n < 40) begin
            half_a(); half_b(); n++;
        end
        checks++;
        if (n >= 40) begin
            errors++;
            $display("FAIL rstmid_wait: x10 write not seen in 40 cycles, addr=%0d", rf_addr);
        end
        rst = 1'b1;
        half_a(); half_b();
        rst = 1'b0;
        checks++;
        if (rf_we !== 1'b0 || rf_addr !== 5'd0 || clear_done !== 1'b0 || clear_busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_rst: we=%b addr=%0d done=%b busy=%b, want 0 0 0 1",
                     rf_we, rf_addr, clear_done, clear_busy);
        end
        n = 0;
        first = 5'd0;
        while (m_clearing && n < 40) begin
            half_a(); half_b();
            if (n == 0) first = rf_addr;
            writes += int'(rf_we);
            n++;
        end
        checks++;
        if (first !== 5'd1 || writes != 31 || clear_busy !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_seq: first=%0d writes=%0d busy=%b, want 1 31 0",
                     first, writes, clear_busy);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            set_random(1'($urandom_range(0, 39) == 0));
            half_a();
            checks++;
            if (req0_ready !== e_rdy0 || req1_ready !== e_rdy1 || clear_busy !== e_busy) begin
                errors++;
                $display("FAIL rand_ctl[%0d]: rdy=%b%b busy=%b, want %b%b %b",
                         i, req0_ready, req1_ready, clear_busy, e_rdy0, e_rdy1, e_busy);
            end
            half_b();
            checks++;
            if (rf_we !== e_we || rf_addr !== e_addr || rf_data !== e_data || clear_done !== e_done) begin
                errors++;
                $display("FAIL rand_wr[%0d]: we=%b addr=%0d data=%h done=%b, want %b %0d %h %b",
                         i, rf_we, rf_addr, rf_data, clear_done, e_we, e_addr, e_data, e_done);
            end
        end
    endtask

    initial begin
        m_clearing = 1'b1; m_idx = 1; m_last = 1; m_g = -1;
        e_we = 0; e_done = 0; e_addr = '0; e_data = '0;
        test_reset();
        test_clear_after_reset();
        test_alternate();
        test_single();
        test_x0_write();
        test_clear_start();
        test_reset_mid_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rf_write_arbiter
`default_nettype wire
